frame_sync: RTL

- Serial PCM frame synchronizer directly downstream of the decoder.
- Consumes the decoder's single-bit output stream and its bit-rate enable.
- Correlates the stream against a programmable, maskable sync word and runs a SEARCH/VERIFY/LOCK/FLYWHEEL state machine.
- Re-emits the data bit-aligned, with frame-start and sync-status markers, for the downstream word packer/FIFO.

---
 rtl/frame_sync_pkg.sv | 26 ++
 rtl/frame_sync_correlator.sv | 54 +++++
 rtl/frame_sync.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/frame_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync_pkg
// Description : Shared definitions for the PCM frame synchronizer: default
//               widths, FSM state encoding and the IRIG standard sync word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package frame_sync_pkg;

  localparam int DEF_SYNC_W = 32;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_ERR_W  = 6;

  // IRIG 106 standard 32-bit frame sync pattern
  localparam logic [31:0] IRIG_SYNC = 32'hFE6B2840;

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_VERIFY   = 2'd1,
    ST_LOCK     = 2'd2,
    ST_FLYWHEEL = 2'd3
  } fs_state_t;

endpackage : frame_sync_pkg
`default_nettype wire

// File: rtl/frame_sync_correlator.sv
`default_nettype none
// ============================================================================
// Module      : sync_correlator
// Description : Serial shift register plus masked-XOR popcount against the
//               programmable sync word. errs is combinational and reflects the
//               register contents *including* the current din, so it is valid
//               in the same cycle as the bit_en that delivers that bit.
// Ports       : clk, rs           - clock, synchronous active-high reset
//               bit_en, din       - serial bit qualifier and data
//               sync_pattern      - sync word, last-received bit at LSB
//               sync_mask         - 1 = bit participates in correlation
//               errs              - mismatch count for next_shift
// Revision    : 1.0 - initial release
// ============================================================================
module sync_correlator
  import frame_sync_pkg::*;
#(
  parameter int SYNC_W = DEF_SYNC_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rs,
  input  logic              bit_en,
  input  logic              din,
  input  logic [SYNC_W-1:0] sync_pattern,
  input  logic [SYNC_W-1:0] sync_mask,
  output logic [ERR_W-1:0]  errs
);

  logic [SYNC_W-1:0] shift_q;
  logic [SYNC_W-1:0] next_shift;
  logic [SYNC_W-1:0] diff;

  assign next_shift = {shift_q[SYNC_W-2:0], din};
  assign diff       = (next_shift ^ sync_pattern) & sync_mask;

  always_comb begin
    errs = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      errs = errs + ERR_W'(diff[i]);
    end
  end

  // History is kept across state changes so SEARCH can re-detect immediately.
  always_ff @(posedge clk) begin
    if (rs) begin
      shift_q <= '0;
    end else if (bit_en) begin
      shift_q <= next_shift;
    end
  end

endmodule : sync_correlator
`default_nettype wire

// File: rtl/frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync
// Description : Serial PCM frame synchronizer. Correlates the decoded bit
//               stream against a maskable sync word and tracks framing with a
//               SEARCH/VERIFY/LOCK/FLYWHEEL state machine. Data is re-emitted
//               one clock later with frame-start and sync markers.
// Ports       : clk, rs               - clock, synchronous active-high reset
//               bit_en, din           - serial bit qualifier and data
//               sync_pattern/mask     - correlation word and participation mask
//               frame_len             - bits per frame incl. sync (min 2)
//               search_tol, lock_tol  - error tolerances
//               verify_cnt            - VERIFY hits needed before LOCK
//               flywheel_cnt          - misses tolerated before SEARCH
//               state                 - current FSM state
//               dout, dout_en         - din / bit_en delayed one clock
//               frame_start           - first bit after a LOCK/FLYWHEEL check
//               sync_pulse            - one clock after an accepted sync
//               sync_errs             - errors at most recent check point
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int SYNC_W = DEF_SYNC_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rs,
  input  logic              bit_en,
  input  logic              din,
  input  logic [SYNC_W-1:0] sync_pattern,
  input  logic [SYNC_W-1:0] sync_mask,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [ERR_W-1:0]  search_tol,
  input  logic [ERR_W-1:0]  lock_tol,
  input  logic [3:0]        verify_cnt,
  input  logic [3:0]        flywheel_cnt,
  output logic [1:0]        state,
  output logic              dout,
  output logic              dout_en,
  output logic              frame_start,
  output logic              sync_pulse,
  output logic [ERR_W-1:0]  sync_errs
);

  fs_state_t        st;
  logic [LEN_W-1:0] bit_cnt;
  logic [4:0]       hits;       // up to verify_cnt+1 = 16
  logic [3:0]       misses;
  logic             fs_pending; // a LOCK/FLYWHEEL check happened; mark next bit

  logic [ERR_W-1:0] errs;
  logic [LEN_W-1:0] len_last;
  logic             is_check;
  logic             hit;
  logic [4:0]       hits_inc;

  sync_correlator #(
    .SYNC_W (SYNC_W),
    .ERR_W  (ERR_W)
  ) u_corr (
    .clk          (clk),
    .rs           (rs),
    .bit_en       (bit_en),
    .din          (din),
    .sync_pattern (sync_pattern),
    .sync_mask    (sync_mask),
    .errs         (errs)
  );

  // Frame lengths below 2 are clamped so the compare index stays >= 1.
  assign len_last = (frame_len < LEN_W'(2)) ? LEN_W'(1) : frame_len - LEN_W'(1);
  assign is_check = (st == ST_SEARCH) || (bit_cnt == len_last);
  assign hit      = (st == ST_SEARCH) ? (errs <= search_tol) : (errs <= lock_tol);
  assign hits_inc = hits + 5'd1;
  assign state    = st;

  always_ff @(posedge clk) begin
    if (rs) begin
      st          <= ST_SEARCH;
      bit_cnt     <= '0;
      hits        <= '0;
      misses      <= '0;
      fs_pending  <= 1'b0;
      dout        <= 1'b0;
      dout_en     <= 1'b0;
      frame_start <= 1'b0;
      sync_pulse  <= 1'b0;
      sync_errs   <= '0;
    end else begin
      dout        <= din;
      dout_en     <= bit_en;
      frame_start <= 1'b0;
      sync_pulse  <= 1'b0;
      if (bit_en) begin
        frame_start <= fs_pending;
        fs_pending  <= 1'b0;
        if (is_check) begin
          // Counter restarts on hit and miss alike so flywheel keeps framing.
          bit_cnt    <= '0;
          sync_errs  <= errs;
          sync_pulse <= hit;
          case (st)
            ST_SEARCH: begin
              if (hit) begin
                hits <= 5'd1;
                if (verify_cnt == 4'd0) begin
                  st         <= ST_LOCK;
                  misses     <= '0;
                  fs_pending <= 1'b1;
                end else begin
                  st <= ST_VERIFY;
                end
              end
            end
            ST_VERIFY: begin
              if (hit) begin
                hits <= hits_inc;
                if (hits_inc > {1'b0, verify_cnt}) begin
                  st         <= ST_LOCK;
                  misses     <= '0;
                  fs_pending <= 1'b1;
                end
              end else begin
                st <= ST_SEARCH;
              end
            end
            ST_LOCK: begin
              if (hit) begin
                misses     <= '0;
                fs_pending <= 1'b1;
              end else if (flywheel_cnt == 4'd0) begin
                st <= ST_SEARCH;
              end else begin
                st         <= ST_FLYWHEEL;
                misses     <= 4'd1;
                fs_pending <= 1'b1;
              end
            end
            default: begin // ST_FLYWHEEL
              if (hit) begin
                st         <= ST_LOCK;
                misses     <= '0;
                fs_pending <= 1'b1;
              end else if (misses == flywheel_cnt) begin
                st <= ST_SEARCH;
              end else begin
                misses     <= misses + 4'd1;
                fs_pending <= 1'b1;
              end
            end
          endcase
        end else begin
          bit_cnt <= bit_cnt + LEN_W'(1);
        end
      end
    end
  end

endmodule : frame_sync
`default_nettype wire
